// File: rtl/axis_pkg.sv
// axis_pkg: width helpers shared by the AXI-Stream FIFO, register slice and width converter.
package axis_pkg;
  function automatic int data_bits(input int tdata_bytes);
    return 8 * tdata_bytes;
  endfunction
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int beat_bits(input int tdata_bytes, input int tid_bits, input int tdest_bits, input int tuser_bits);
    return 8 * tdata_bytes + 2 * tdata_bytes + 1 + tid_bits + tdest_bits + tuser_bits;
  endfunction
endpackage

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem: simple dual-port beat storage, synchronous write, asynchronous read.
module axis_fifo_mem #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/axis_fifo.sv
// axis_fifo: synchronous AXI-Stream FIFO with full sideband, fill status and optional
// store-and-forward packet gating.
module axis_fifo import axis_pkg::*; #(
  parameter int TDATA_BYTES = 4,
  parameter int TID_BITS = 1,
  parameter int TDEST_BITS = 1,
  parameter int TUSER_BITS = 1,
  parameter int DEPTH = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [data_bits(TDATA_BYTES)-1:0]     s_axis_tdata,
  input  logic [TDATA_BYTES-1:0]                s_axis_tstrb,
  input  logic [TDATA_BYTES-1:0]                s_axis_tkeep,
  input  logic                                  s_axis_tlast,
  input  logic [TID_BITS-1:0]                   s_axis_tid,
  input  logic [TDEST_BITS-1:0]                 s_axis_tdest,
  input  logic [TUSER_BITS-1:0]                 s_axis_tuser,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [data_bits(TDATA_BYTES)-1:0]     m_axis_tdata,
  output logic [TDATA_BYTES-1:0]                m_axis_tstrb,
  output logic [TDATA_BYTES-1:0]                m_axis_tkeep,
  output logic                                  m_axis_tlast,
  output logic [TID_BITS-1:0]                   m_axis_tid,
  output logic [TDEST_BITS-1:0]                 m_axis_tdest,
  output logic [TUSER_BITS-1:0]                 m_axis_tuser,
  output logic [cnt_bits(DEPTH)-1:0]            count,
  output logic [cnt_bits(DEPTH)-1:0]            pkt_count
);
  localparam int PB = ptr_bits(DEPTH);
  localparam int AW = PB - 1;
  localparam int CB = cnt_bits(DEPTH);
  localparam int BB = beat_bits(TDATA_BYTES, TID_BITS, TDEST_BITS, TUSER_BITS);
  logic [PB-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CB-1:0] pkt_q, pkt_d, count_d;
  logic bypass_q, bypass_d, ready_q, ready_d, wr, rd;
  logic [BB-1:0] wr_beat, rd_beat;
  assign wr_beat = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};
  assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = rd_beat;
  // Pointer difference with the wrap bit gives 0..DEPTH, so it doubles as the beat count.
  assign count = CB'(wr_ptr_q - rd_ptr_q);
  assign pkt_count = pkt_q;
  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (count != '0) && ((PACKET_MODE == 0) || (pkt_q != '0) || bypass_q);
  assign wr = s_axis_tvalid && ready_q;
  assign rd = m_axis_tvalid && m_axis_tready;
  always_comb begin
    wr_ptr_d = wr_ptr_q + PB'(wr);
    rd_ptr_d = rd_ptr_q + PB'(rd);
    count_d = CB'(wr_ptr_d - rd_ptr_d);
    pkt_d = pkt_q + CB'(wr && s_axis_tlast) - CB'(rd && m_axis_tlast);
    bypass_d = (PACKET_MODE != 0) && !(rd && m_axis_tlast) && (bypass_q || (count == CB'(DEPTH) && pkt_q == '0));
    ready_d = count_d < CB'(DEPTH);
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pkt_q <= '0;
      bypass_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pkt_q <= pkt_d;
      bypass_q <= bypass_d;
      ready_q <= ready_d;
    end
  end
  axis_fifo_mem #(.W(BB), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(aclk),
    .we(wr),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(wr_beat),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(rd_beat)
  );
endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: directed and table-driven checks of a cut-through FIFO (DEPTH=16)
// and a store-and-forward FIFO (DEPTH=4) sharing the slave-side payload.
module tb_axis_fifo;
  logic aclk = 1'b0, areset = 1'b1;
  logic v0, r0m, v1, r1m;
  logic [31:0] sd;
  logic [3:0] ss, sk;
  logic sl, si, sde, su;
  logic s0r, m0v, m0l, m0i, m0de, m0u;
  logic [31:0] m0d;
  logic [3:0] m0s, m0k;
  logic [4:0] c0, p0;
  logic s1r, m1v, m1l, m1i, m1de, m1u;
  logic [31:0] m1d;
  logic [3:0] m1s, m1k;
  logic [2:0] c1, p1;
  int total = 0, bad = 0;
  int wi, ri, cyc, sent, rcv;
  bit saw, w, r;
  logic [31:0] q[$];
  typedef struct {
    logic sv; logic [31:0] d; logic l; logic mr;
    int cnt; int pkt; logic mv; logic sr; logic [31:0] md;
  } vec_t;
  vec_t tbl[8];

  always #5 aclk = ~aclk;

  axis_fifo #(.DEPTH(16), .PACKET_MODE(0)) u0 (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(v0), .s_axis_tready(s0r), .s_axis_tdata(sd), .s_axis_tstrb(ss), .s_axis_tkeep(sk),
    .s_axis_tlast(sl), .s_axis_tid(si), .s_axis_tdest(sde), .s_axis_tuser(su),
    .m_axis_tvalid(m0v), .m_axis_tready(r0m), .m_axis_tdata(m0d), .m_axis_tstrb(m0s), .m_axis_tkeep(m0k),
    .m_axis_tlast(m0l), .m_axis_tid(m0i), .m_axis_tdest(m0de), .m_axis_tuser(m0u),
    .count(c0), .pkt_count(p0)
  );

  axis_fifo #(.DEPTH(4), .PACKET_MODE(1)) u1 (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(v1), .s_axis_tready(s1r), .s_axis_tdata(sd), .s_axis_tstrb(ss), .s_axis_tkeep(sk),
    .s_axis_tlast(sl), .s_axis_tid(si), .s_axis_tdest(sde), .s_axis_tuser(su),
    .m_axis_tvalid(m1v), .m_axis_tready(r1m), .m_axis_tdata(m1d), .m_axis_tstrb(m1s), .m_axis_tkeep(m1k),
    .m_axis_tlast(m1l), .m_axis_tid(m1i), .m_axis_tdest(m1de), .m_axis_tuser(m1u),
    .count(c1), .pkt_count(p1)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b1, 32'h0};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 2, 0, 1'b0, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 3, 0, 1'b0, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 32'hA3, 1'b1, 1'b1, 4, 1, 1'b1, 1'b0, 32'hA0};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 3, 1, 1'b1, 1'b1, 32'hA1};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 2, 1, 1'b1, 1'b1, 32'hA2};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 1, 1, 1'b1, 1'b1, 32'hA3};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 32'h0};
    v0 = 0; v1 = 0; r0m = 0; r1m = 0; sd = 0; ss = 0; sk = 0; sl = 0; si = 0; sde = 0; su = 0;
    repeat (2) @(negedge aclk);
    chk("rst_sready", s0r, 0);
    chk("rst_mvalid", m0v, 0);
    chk("rst_count", c0, 0);
    chk("rst_pkt", p0, 0);
    areset = 0;
    @(negedge aclk);
    chk("release_sready0", s0r, 1);
    chk("release_sready1", s1r, 1);

    for (int i = 0; i < 16; i++) begin
      chk("fill_sready", s0r, 1);
      v0 = 1; sd = 32'(i);
      @(negedge aclk);
    end
    v0 = 0;
    chk("full_count", c0, 16);
    chk("full_sready", s0r, 0);
    chk("full_mvalid", m0v, 1);
    v0 = 1; sd = 32'd99; r0m = 1;
    chk("full_head", m0d, 0);
    @(negedge aclk);
    v0 = 0;
    chk("full_refuses_write", c0, 15);
    for (int i = 1; i < 16; i++) begin
      chk("drain_data", {m0v, m0d}, {1'b1, 32'(i)});
      @(negedge aclk);
    end
    chk("drain_count", c0, 0);
    chk("drain_mvalid", m0v, 0);
    r0m = 0;

    ss = 4'hF; sk = 4'hF; si = 1; sde = 1; r0m = 1;
    for (int i = 0; i < 100; i++) begin
      v0 = 1; sd = 32'(100 + i);
      @(negedge aclk);
      chk("stream", {m0v, c0, m0i, m0de, m0k, m0s, m0d}, {1'b1, 5'd1, 1'b1, 1'b1, 4'hF, 4'hF, 32'(100 + i)});
    end
    v0 = 0;
    @(negedge aclk);
    chk("stream_drain_count", c0, 0);
    chk("stream_drain_mvalid", m0v, 0);
    r0m = 0; si = 0; sde = 0; ss = 0; sk = 0;

    for (int k = 0; k < 8; k++) begin
      v1 = tbl[k].sv; sd = tbl[k].d; sl = tbl[k].l; r1m = tbl[k].mr;
      @(negedge aclk);
      chk($sformatf("tbl%0d_count", k), c1, tbl[k].cnt);
      chk($sformatf("tbl%0d_pkt", k), p1, tbl[k].pkt);
      chk($sformatf("tbl%0d_flags", k), {m1v, s1r}, {tbl[k].mv, tbl[k].sr});
      if (tbl[k].mv) chk($sformatf("tbl%0d_data", k), m1d, tbl[k].md);
    end
    v1 = 0; sl = 0;

    wi = 0; ri = 0; cyc = 0; saw = 0; r1m = 1;
    while (ri < 10 && cyc < 200) begin
      v1 = wi < 10; sd = 32'h200 + 32'(wi); sl = (wi == 9);
      if (m1v && p1 == 0) saw = 1;
      chk("bp_count_le_depth", c1 <= 3'd4, 1);
      if (m1v) chk("bp_beat", {m1l, m1d}, {ri == 9, 32'h200 + 32'(ri)});
      w = v1 && s1r; r = m1v && r1m;
      @(posedge aclk);
      wi += int'(w); ri += int'(r);
      @(negedge aclk);
      cyc++;
    end
    v1 = 0; sl = 0;
    chk("bp_all_delivered", ri, 10);
    chk("bp_bypass_used", saw, 1);
    chk("bp_end_count", c1, 0);
    for (int i = 0; i < 3; i++) begin
      v1 = 1; sd = 32'h300 + 32'(i);
      @(negedge aclk);
    end
    v1 = 0;
    chk("bp_cleared_count", c1, 3);
    chk("bp_cleared_gate", m1v, 0);

    sent = 0; rcv = 0; cyc = 0; q.delete();
    while (rcv < 2000 && cyc < 20000) begin
      v0 = (sent < 2000) && ($urandom_range(0, 3) != 0);
      sd = $urandom;
      r0m = $urandom_range(0, 2) != 0;
      chk("rnd_count", c0, q.size());
      chk("rnd_flags", {s0r, m0v}, {q.size() < 16, q.size() != 0});
      if (m0v && q.size() > 0) chk("rnd_data", m0d, q[0]);
      w = v0 && s0r; r = m0v && r0m;
      @(posedge aclk);
      if (r && q.size() > 0) begin
        void'(q.pop_front());
        rcv++;
      end
      if (w) begin
        q.push_back(sd);
        sent++;
      end
      @(negedge aclk);
      cyc++;
    end
    v0 = 0; r0m = 0;
    chk("rnd_all_received", rcv, 2000);

    for (int i = 0; i < 7; i++) begin
      v0 = 1; sd = 32'h400 + 32'(i); sl = (i == 2 || i == 5);
      @(negedge aclk);
    end
    v0 = 0; sl = 0;
    chk("pre_rst_count", c0, 7);
    chk("pre_rst_pkt", p0, 2);
    #2 areset = 1;
    #1;
    chk("async_rst_count", c0, 0);
    chk("async_rst_pkt", p0, 0);
    chk("async_rst_mvalid", m0v, 0);
    chk("async_rst_sready", s0r, 0);
    chk("async_rst_count1", c1, 0);
    @(negedge aclk);
    areset = 0;
    @(negedge aclk);
    chk("post_rst_idle", m0v, 0);
    v0 = 1; sd = 32'h55; sl = 1;
    @(negedge aclk);
    v0 = 0; sl = 0;
    chk("post_rst_beat", {m0v, m0l, m0d}, {1'b1, 1'b1, 32'h55});
    chk("post_rst_counts", {c0, p0}, {5'd1, 5'd1});
    r0m = 1;
    @(negedge aclk);
    r0m = 0;
    chk("post_rst_drain", {m0v, c0, p0}, {1'b0, 5'd0, 5'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
